// File: rtl/fp_sub_seq.sv
// fp_sub_seq: multi-cycle IEEE-754 single-precision subtractor, Diff = A - B, one bit of align/normalise per clock.
// Define FP_SUB_SPECIALS_EN to add NaN/Inf operand detection with a one-cycle result path.
module fp_sub_seq #(
    parameter int MAX_ALIGN = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] Diff
);
    typedef enum logic [1:0] {IDLE, ALIGN, ADD, NORM} state_t;

    localparam logic [7:0] MAX_D = 8'(MAX_ALIGN);

    state_t      state, next_state;
    logic [23:0] ma, mb;
    logic        sa, sb;
    logic [7:0]  exp_w, d;
    logic        shift_b;
    logic [24:0] sum;
    logic        sum_sign;
    logic        special;
    logic [31:0] special_res;
    logic        pack_now;

    logic [7:0]  exp_a, exp_b;
    logic [23:0] man_a, man_b;
    logic        special_hit;
    logic [31:0] special_val;

    // Zero exponent flushes the operand (and any denormal) to a zero mantissa.
    assign exp_a = A[30:23];
    assign exp_b = B[30:23];
    assign man_a = (exp_a == 8'd0) ? 24'd0 : {1'b1, A[22:0]};
    assign man_b = (exp_b == 8'd0) ? 24'd0 : {1'b1, B[22:0]};

`ifdef FP_SUB_SPECIALS_EN
    logic nan_a, nan_b, inf_a, inf_b;

    assign nan_a = (exp_a == 8'hFF) && (A[22:0] != 23'd0);
    assign nan_b = (exp_b == 8'hFF) && (B[22:0] != 23'd0);
    assign inf_a = (exp_a == 8'hFF) && (A[22:0] == 23'd0);
    assign inf_b = (exp_b == 8'hFF) && (B[22:0] == 23'd0);

    // B's sign is inverted: every comparison below is on effective signs.
    always_comb begin
        special_hit = (exp_a == 8'hFF) || (exp_b == 8'hFF);
        special_val = 32'h7FC00000;
        if (nan_a || nan_b)
            special_val = 32'h7FC00000;
        else if (inf_a && inf_b)
            special_val = (A[31] == ~B[31]) ? {A[31], 8'hFF, 23'h0} : 32'h7FC00000;
        else if (inf_a)
            special_val = {A[31], 8'hFF, 23'h0};
        else if (inf_b)
            special_val = {~B[31], 8'hFF, 23'h0};
    end
`else
    assign special_hit = 1'b0;
    assign special_val = 32'h0;
`endif

    assign pack_now = special || (sum == 25'd0) || sum[24] || sum[23] || (exp_w <= 8'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // An oversized difference still spends one ALIGN cycle with d forced to 0.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = special_hit ? NORM : ALIGN;
            ALIGN:   if (d == 8'd0) next_state = ADD;
            ADD:     next_state = NORM;
            NORM:    if (pack_now) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma          <= 24'd0;
            mb          <= 24'd0;
            sa          <= 1'b0;
            sb          <= 1'b0;
            exp_w       <= 8'd0;
            d           <= 8'd0;
            shift_b     <= 1'b0;
            sum         <= 25'd0;
            sum_sign    <= 1'b0;
            special     <= 1'b0;
            special_res <= 32'h0;
            done        <= 1'b0;
            Diff        <= 32'h0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ma          <= man_a;
                        mb          <= man_b;
                        sa          <= A[31];
                        sb          <= ~B[31];
                        special     <= special_hit;
                        special_res <= special_val;
                        if (exp_a >= exp_b) begin
                            exp_w   <= exp_a;
                            d       <= exp_a - exp_b;
                            shift_b <= 1'b1;
                        end else begin
                            exp_w   <= exp_b;
                            d       <= exp_b - exp_a;
                            shift_b <= 1'b0;
                        end
                    end
                end
                ALIGN: begin
                    if (d > MAX_D) begin
                        if (shift_b) mb <= 24'd0;
                        else         ma <= 24'd0;
                        d <= 8'd0;
                    end else if (d != 8'd0) begin
                        if (shift_b) mb <= mb >> 1;
                        else         ma <= ma >> 1;
                        d <= d - 8'd1;
                    end
                end
                ADD: begin
                    if (sa == sb) begin
                        sum      <= {1'b0, ma} + {1'b0, mb};
                        sum_sign <= sa;
                    end else if (ma > mb) begin
                        sum      <= {1'b0, ma - mb};
                        sum_sign <= sa;
                    end else if (mb > ma) begin
                        sum      <= {1'b0, mb - ma};
                        sum_sign <= sb;
                    end else begin
                        sum      <= 25'd0;
                        sum_sign <= 1'b0;
                    end
                end
                NORM: begin
                    if (pack_now)
                        done <= 1'b1;
                    if (special)
                        Diff <= special_res;
                    else if (sum == 25'd0)
                        Diff <= 32'h0;
                    else if (sum[24])
                        Diff <= (exp_w >= 8'd254) ? {sum_sign, 8'hFF, 23'h0}
                                                  : {sum_sign, exp_w + 8'd1, sum[23:1]};
                    else if (sum[23])
                        Diff <= {sum_sign, exp_w, sum[22:0]};
                    else if (exp_w <= 8'd1)
                        Diff <= {sum_sign, 31'h0};
                    else begin
                        sum   <= sum << 1;
                        exp_w <= exp_w - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_sub_seq.sv
// tb_fp_sub_seq: scoreboard bench for fp_sub_seq; directed test-plan vectors plus random operands
// checked against an arithmetic reference model (result value and start-to-done latency).
module tb_fp_sub_seq;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a_in, b_in;
    logic        busy, done;
    logic [31:0] Diff;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] diff;
        int          lat;
        int          start_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks;
    int   failures;
    int   cyc;

    fp_sub_seq #(.MAX_ALIGN(25)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (a_in),
        .B     (b_in),
        .busy  (busy),
        .done  (done),
        .Diff  (Diff)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Reference: exact integer alignment/sum, then normalise; latency from alignment steps and left shifts.
    function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output int lat);
        int     ea, eb, e, d, k, al;
        longint ma, mb, s, mag;
        logic   sa, sb, sr;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        sa = a[31];
        sb = ~b[31];
`ifdef FP_SUB_SPECIALS_EN
        if (ea == 255 || eb == 255) begin
            lat = 1;
            if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0))
                r = 32'h7FC00000;
            else if (ea == 255 && eb == 255)
                r = (sa == sb) ? {sa, 8'hFF, 23'h0} : 32'h7FC00000;
            else if (ea == 255)
                r = {sa, 8'hFF, 23'h0};
            else
                r = {sb, 8'hFF, 23'h0};
            return;
        end
`endif
        ma = (ea == 0) ? 0 : (longint'(1) << 23) + longint'(a[22:0]);
        mb = (eb == 0) ? 0 : (longint'(1) << 23) + longint'(b[22:0]);
        e  = (ea >= eb) ? ea : eb;
        d  = (ea >= eb) ? ea - eb : eb - ea;
        if (d > 25) begin
            al = 1;
            if (ea >= eb) mb = 0; else ma = 0;
        end else begin
            al = d;
            if (ea >= eb) mb = mb >> d; else ma = ma >> d;
        end
        s = (sa ? -ma : ma) + (sb ? -mb : mb);
        k = 0;
        if (s == 0) begin
            r = 32'h0;
        end else begin
            sr  = (s < 0);
            mag = (s < 0) ? -s : s;
            if (mag >= (longint'(1) << 24)) begin
                mag = mag >> 1;
                e++;
                r = (e >= 255) ? {sr, 8'hFF, 23'h0} : {sr, 8'(e), 23'(mag)};
            end else begin
                while (mag < (longint'(1) << 23) && e > 1) begin
                    mag = mag << 1;
                    e--;
                    k++;
                end
                r = (mag < (longint'(1) << 23)) ? {sr, 31'h0} : {sr, 8'(e), 23'(mag)};
            end
        end
        lat = 3 + al + k;
    endfunction

    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] diff_exp, input int lat_exp);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("[TB] FAIL idle_wait: busy got 1, expected 0");
        end
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        e.a = a;
        e.b = b;
        e.diff = diff_exp;
        e.lat = lat_exp;
        e.start_cyc = cyc + 1;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check_output("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic apply_random(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        int          lat;
        ref_model(a, b, r, lat);
        apply_stimulus(a, b, r, lat);
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((sb_q.size() != 0 || busy) && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (sb_q.size() != 0 || busy) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain: pending=%0d busy=%0d, expected 0 and 0", sb_q.size(), busy);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done: got done with Diff=%h, expected no done", Diff);
            end else begin
                e = sb_q.pop_front();
                check_output($sformatf("diff(%h-%h)", e.a, e.b), Diff, e.diff);
                check_output($sformatf("latency(%h-%h)", e.a, e.b), 32'(cyc - e.start_cyc), 32'(e.lat));
                check_output("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    initial begin
        logic [31:0] ra, rb;
        int          mode;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a_in     = 32'h0;
        b_in     = 32'h0;
        repeat (3) @(negedge clk);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_done", 32'(done), 32'd0);
        check_output("reset_diff", Diff, 32'h0);
        rst_n = 1'b1;

        apply_stimulus(32'h40400000, 32'h3F800000, 32'h40000000, 4);
        apply_stimulus(32'h3F800000, 32'h3F800000, 32'h00000000, 3);
        apply_stimulus(32'hBF800000, 32'hBF800000, 32'h00000000, 3);
        apply_stimulus(32'h3F800000, 32'hBF800000, 32'h40000000, 3);
        apply_stimulus(32'h3FC00000, 32'h3FA00000, 32'h3E800000, 5);
        apply_stimulus(32'h7F000000, 32'h7F000000, 32'h00000000, 3);
`ifdef FP_SUB_SPECIALS_EN
        apply_stimulus(32'h7F800000, 32'h7F800000, 32'h7FC00000, 1);
        apply_stimulus(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1);
`else
        apply_stimulus(32'h7F800000, 32'h7F800000, 32'h00000000, 3);
        apply_stimulus(32'h7FC00001, 32'h3F800000, 32'h7FC00001, 4);
`endif
        // A second start while busy must not produce a second done.
        apply_stimulus(32'h3F800000, 32'h30800000, 32'h3F800000, 4);
        a_in  = 32'h40400000;
        b_in  = 32'h3F800000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (10) @(negedge clk);

        // Reset asserted in ALIGN abandons the operation.
        a_in  = 32'h3F800000;
        b_in  = 32'h3E000000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("midop_reset_busy", 32'(busy), 32'd0);
        check_output("midop_reset_done", 32'(done), 32'd0);
        check_output("midop_reset_diff", Diff, 32'h0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            mode = int'($urandom_range(0, 4));
            ra = $urandom;
            rb = $urandom;
            ra[30:23] = 8'($urandom_range(1, 254));
            case (mode)
                0: rb[30:23] = 8'($urandom_range(1, 254));
                1: begin
                    rb = ra;
                    rb[5:0] = 6'($urandom);
                end
                2: begin
                    ra[30:23] = 8'($urandom_range(1, 3));
                    rb[30:23] = 8'($urandom_range(1, 3));
                    rb[31] = ra[31];
                    rb[22:0] = ra[22:0] ^ 23'($urandom_range(0, 255));
                end
                3: rb[30:23] = 8'd0;
                default: rb[30:23] = 8'(int'(ra[30:23]) - int'($urandom_range(0, 3)) + 1);
            endcase
            apply_random(ra, rb);
        end
        wait_drain();
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
